tlp_tx_arbiter: RTL and testbench

Packet-granular round-robin arbiter that lets NUM_PORTS TLP sources share one Xilinx UltraScale+ AXI-Stream TX interface, such as the RQ or CC request/completion path. It sits between the LitePCIe TX sources and the TX-side adapter. Packets are never interleaved: once a port is granted, it keeps the grant until its tlast beat is accepted. Grant handoff to a different pending port costs no bubble cycle.

---
 rtl/tlp_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_tlp_tx_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_tx_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI-Stream TLP sources onto one TX stream.
// The grant is held from the first beat until the tlast handshake; handoff to another pending port costs no bubble.
module tlp_tx_arbiter #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 32,
    parameter int USER_WIDTH = 62,
    parameter int NUM_PORTS  = 4
) (
    input  logic                             user_clk,
    input  logic                             user_reset_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_axis_tuser,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    output logic [NUM_PORTS-1:0]             s_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic [3:0]                       m_axis_tready,
    output logic [NUM_PORTS-1:0]             grant,
    output logic                             busy
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     rr_ptr;

    logic [NUM_PORTS-1:0] req_x;
    logic                 eop;
    logic [IDX_W-1:0]     idle_win;
    logic [IDX_W-1:0]     eop_win;
    logic                 unused_tready_hi;

    // First requester strictly after 'after', wrapping modulo NUM_PORTS; the descending
    // scan lets the closest candidate overwrite the farther ones.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [IDX_W-1:0]     after);
        logic [IDX_W-1:0] win;
        int               idx;
        win = after;
        for (int d = NUM_PORTS; d >= 1; d--) begin
            idx = (int'(after) + d) % NUM_PORTS;
            if (req[idx]) win = IDX_W'(idx);
        end
        return win;
    endfunction

    assign unused_tready_hi = ^m_axis_tready[3:1];

    always_comb begin
        req_x          = s_axis_tvalid;
        req_x[gnt_idx] = 1'b0;
    end

    assign eop      = (state == BUSY) && s_axis_tvalid[gnt_idx] && m_axis_tready[0]
                      && s_axis_tlast[gnt_idx];
    assign idle_win = rr_pick(s_axis_tvalid, rr_ptr);
    assign eop_win  = rr_pick(req_x, gnt_idx);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state   <= IDLE;
            gnt_idx <= '0;
            rr_ptr  <= IDX_W'(NUM_PORTS - 1);
            grant   <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        state   <= BUSY;
                        gnt_idx <= idle_win;
                        rr_ptr  <= idle_win;
                        grant   <= NUM_PORTS'(1) << idle_win;
                        busy    <= 1'b1;
                    end
                end
                BUSY: begin
                    if (eop) begin
                        if (|req_x) begin
                            gnt_idx <= eop_win;
                            rr_ptr  <= eop_win;
                            grant   <= NUM_PORTS'(1) << eop_win;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: every output gets a default before the conditional so no latch is inferred.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (state == BUSY) begin
            m_axis_tdata           = s_axis_tdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tkeep           = s_axis_tkeep[gnt_idx*KEEP_WIDTH +: KEEP_WIDTH];
            m_axis_tuser           = s_axis_tuser[gnt_idx*USER_WIDTH +: USER_WIDTH];
            m_axis_tlast           = s_axis_tlast[gnt_idx];
            m_axis_tvalid          = s_axis_tvalid[gnt_idx];
            s_axis_tready[gnt_idx] = m_axis_tready[0];
        end
    end

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Testbench for tlp_tx_arbiter: directed scenarios plus randomized traffic, all checked every cycle
// against a packet-level round-robin reference model (owner port, last served port, per-port beat queues).
module tb_tlp_tx_arbiter;

    localparam int DW = 256;
    localparam int KW = DW / 32;
    localparam int UW = 62;
    localparam int NP = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic              user_clk = 1'b0;
    logic              user_reset_n;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP*KW-1:0]  s_axis_tkeep;
    logic [NP*UW-1:0]  s_axis_tuser;
    logic [NP-1:0]     s_axis_tlast;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic [3:0]        m_axis_tready;
    logic [NP-1:0]     grant;
    logic              busy;

    tlp_tx_arbiter #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .NUM_PORTS(NP)
    ) dut (
        .user_clk      (user_clk),
        .user_reset_n  (user_reset_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 user_clk = ~user_clk;

    beat_t         src_q [NP][$];
    logic [NP-1:0] src_valid;
    int            valid_pct;
    int            ready_pct;
    int            rdy_pat[$];
    int            owner;
    int            last_served;
    int            cyc;
    int            n_checks;
    int            n_errors;
    int            beat_cyc[$];
    int            beat_port[$];
    int            order[$];
    logic [NP-1:0] prev_grant_obs;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Nearest requesting port strictly after 'after' in circular order, or -1 if none.
    function automatic int next_after(input logic [NP-1:0] req, input int after);
        for (int d = 1; d <= NP; d++) begin
            if (req[(after + d) % NP]) return (after + d) % NP;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NP-1:0] g);
        for (int i = 0; i < NP; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic bit pending();
        for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load(input int p, input int nbeats);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b.data = rand_wide();
            b.keep = KW'($urandom);
            b.user = {30'($urandom), $urandom};
            b.last = (k == nbeats - 1);
            src_q[p].push_back(b);
        end
    endtask

    task automatic drive();
        beat_t b;
        logic  r0;
        if (rdy_pat.size() > 0) r0 = (rdy_pat[cyc % rdy_pat.size()] != 0);
        else                    r0 = ($urandom_range(99) < ready_pct);
        m_axis_tready = {3'($urandom), r0};
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() == 0) src_valid[p] = 1'b0;
            else if (!src_valid[p] && $urandom_range(99) < valid_pct) src_valid[p] = 1'b1;
            b = (src_q[p].size() > 0) ? src_q[p][0] : '0;
            s_axis_tdata[p*DW +: DW] = b.data;
            s_axis_tkeep[p*KW +: KW] = b.keep;
            s_axis_tuser[p*UW +: UW] = b.user;
            s_axis_tlast[p]          = b.last;
        end
        s_axis_tvalid = src_valid;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"},  DW'(grant),         '0);
        check({tag, "_busy"},   DW'(busy),          '0);
        check({tag, "_tvalid"}, DW'(m_axis_tvalid), '0);
        check({tag, "_tlast"},  DW'(m_axis_tlast),  '0);
        check({tag, "_tdata"},  m_axis_tdata,       '0);
        check({tag, "_tkeep"},  DW'(m_axis_tkeep),  '0);
        check({tag, "_tuser"},  DW'(m_axis_tuser),  '0);
        check({tag, "_sready"}, DW'(s_axis_tready), '0);
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model at the edge.
    task automatic step();
        int            go;
        logic          m0;
        beat_t         eb;
        logic [NP-1:0] exp_rdy;
        logic [NP-1:0] acc;
        logic [NP-1:0] v;
        @(negedge user_clk);
        go      = owner;
        m0      = m_axis_tready[0];
        acc     = '0;
        exp_rdy = '0;
        check("busy", DW'(busy), DW'(go >= 0));
        if (go >= 0) begin
            eb          = (src_q[go].size() > 0) ? src_q[go][0] : '0;
            exp_rdy[go] = m0;
            check("grant",  DW'(grant),         DW'(NP'(1) << go));
            check("tvalid", DW'(m_axis_tvalid), DW'(src_valid[go]));
            check("tlast",  DW'(m_axis_tlast),  DW'(eb.last));
            check("tdata",  m_axis_tdata,       eb.data);
            check("tkeep",  DW'(m_axis_tkeep),  DW'(eb.keep));
            check("tuser",  DW'(m_axis_tuser),  DW'(eb.user));
            acc[go] = src_valid[go] & m0;
        end else begin
            check_zero("idle");
        end
        check("s_tready", DW'(s_axis_tready), DW'(exp_rdy));
        if (m_axis_tvalid && m0) begin
            beat_cyc.push_back(cyc);
            beat_port.push_back(onehot_idx(grant));
        end
        if (grant != '0 && grant != prev_grant_obs) order.push_back(onehot_idx(grant));
        prev_grant_obs = grant;

        @(posedge user_clk);
        #1;
        v = src_valid;
        if (go < 0) begin
            if (v != '0) begin
                owner       = next_after(v, last_served);
                last_served = owner;
            end
        end else if (acc[go] && src_q[go][0].last) begin
            v[go] = 1'b0;
            owner = next_after(v, go);
            if (owner >= 0) last_served = owner;
        end
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                void'(src_q[p].pop_front());
                src_valid[p] = 1'b0;
            end
        end
        cyc++;
        drive();
    endtask

    task automatic run_idle(input string tag, input int max);
        int n;
        n = 0;
        while ((pending() || owner >= 0) && n < max) begin
            step();
            n++;
        end
        check({tag, "_drain"}, DW'(n < max), DW'(1));
        step();
    endtask

    task automatic do_reset();
        user_reset_n = 1'b0;
        #1;
        check_zero("rst");
        for (int p = 0; p < NP; p++) src_q[p].delete();
        src_valid   = '0;
        owner       = -1;
        last_served = NP - 1;
        drive();
        repeat (3) @(posedge user_clk);
        #1;
        user_reset_n = 1'b1;
        drive();
    endtask

    task automatic clear_logs();
        beat_cyc.delete();
        beat_port.delete();
        order.delete();
        prev_grant_obs = '0;
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        check({tag, "_n"}, DW'(order.size()), DW'(exp.size()));
        for (int k = 0; k < exp.size() && k < order.size(); k++)
            check($sformatf("%s_%0d", tag, k), DW'(order[k]), DW'(exp[k]));
    endtask

    task automatic check_beat_cycles(input string tag, input int c0, input int n);
        check({tag, "_beats"}, DW'(beat_cyc.size()), DW'(n));
        for (int k = 0; k < n && k < beat_cyc.size(); k++)
            check($sformatf("%s_cyc%0d", tag, k), DW'(beat_cyc[k] - c0), DW'(k + 1));
    endtask

    initial begin
        int c0;
        int tot;
        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        valid_pct     = 100;
        ready_pct     = 100;
        src_valid     = '0;
        owner         = -1;
        last_served   = NP - 1;
        user_reset_n  = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = '0;
        s_axis_tvalid = '0;
        m_axis_tready = '0;
        clear_logs();
        #2;
        do_reset();

        // Single port: 3-beat packet on port 2, first beat one cycle after the request.
        clear_logs();
        c0 = cyc;
        load(2, 3);
        drive();
        run_idle("single", 50);
        check_order("single_order", '{2});
        check_beat_cycles("single", c0, 3);

        // Contention right after reset: ports 0,1,3 in order with no gaps.
        do_reset();
        clear_logs();
        c0 = cyc;
        load(0, 2);
        load(1, 2);
        load(3, 2);
        drive();
        run_idle("contend", 50);
        check_order("contend_order", '{0, 1, 3});
        check_beat_cycles("contend", c0, 6);

        // Backpressure: ready follows a 1,0,0,1 pattern on a 4-beat packet.
        clear_logs();
        rdy_pat = '{1, 0, 0, 1};
        load(1, 4);
        drive();
        run_idle("bp", 100);
        rdy_pat.delete();
        check("bp_beats", DW'(beat_cyc.size()), DW'(4));
        for (int k = 0; k < beat_port.size(); k++)
            check($sformatf("bp_port%0d", k), DW'(beat_port[k]), DW'(1));

        // Repeat requester: one idle arbitration cycle between back-to-back packets.
        clear_logs();
        for (int k = 0; k < 5; k++) load(0, 1);
        drive();
        run_idle("repeat", 100);
        check_order("repeat_order", '{0, 0, 0, 0, 0});
        check("repeat_beats", DW'(beat_cyc.size()), DW'(5));
        for (int k = 1; k < beat_cyc.size(); k++)
            check($sformatf("repeat_gap%0d", k), DW'(beat_cyc[k] - beat_cyc[k-1]), DW'(2));

        // Round-robin pointer: after port 3, {0,2} -> 0, then {2,3} -> 2.
        clear_logs();
        load(3, 1);
        drive();
        run_idle("rr_a", 50);
        clear_logs();
        load(0, 2);
        load(2, 1);
        drive();
        step();
        step();
        load(3, 1);
        drive();
        run_idle("rr_b", 50);
        check_order("rr_order", '{0, 2, 3});

        // Reset during beat 2 of 5 on port 1, then port 0 alone is served first.
        clear_logs();
        load(1, 5);
        drive();
        for (int n = 0; n < 20 && beat_cyc.size() < 1; n++) step();
        check("midrst_pre_valid", DW'(m_axis_tvalid), DW'(1));
        do_reset();
        clear_logs();
        c0 = cyc;
        load(0, 1);
        drive();
        run_idle("postrst", 50);
        check_order("postrst_order", '{0});
        check_beat_cycles("postrst", c0, 1);

        // Randomized traffic with source stalls and downstream backpressure.
        valid_pct = 70;
        ready_pct = 70;
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            tot = 0;
            for (int p = 0; p < NP; p++) begin
                for (int k = 0; k < 5; k++) begin
                    int nb;
                    nb = $urandom_range(4, 1);
                    tot += nb;
                    load(p, nb);
                end
            end
            drive();
            run_idle($sformatf("rand%0d", r), 4000);
            check($sformatf("rand%0d_beats", r), DW'(beat_cyc.size()), DW'(tot));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
